// File: rtl/axi_lite_slave_regfile_pkg.sv
// Shared AXI-lite definitions for the register-file slave.
// Contents:
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_t              : write-channel FSM encoding
//   rd_state_t              : read-channel FSM encoding
package axi_lite_slave_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'b00,
        WR_GOT_AW = 2'b01,
        WR_GOT_W  = 2'b10,
        WR_RESP   = 2'b11
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage for the AXI-lite slave: one write port, one read port, flat dump.
// Ports:
//   i_clk, i_rst              : clock, asynchronous active-high reset (clears all registers)
//   i_we, i_waddr, i_wdata    : write strobe / address / data; out-of-range writes are dropped
//   o_waddr_ok                : i_waddr is a valid register index
//   i_raddr, o_rdata          : combinational read; out-of-range returns 0
//   o_raddr_ok                : i_raddr is a valid register index
//   o_regs                    : all registers, reg i at [i*DATA_WD +: DATA_WD]
module axi_lite_regfile #(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned ADDR_WD = 8,
    parameter int unsigned REG_NUM = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [ADDR_WD-1:0]         i_waddr,
    input  logic [DATA_WD-1:0]         i_wdata,
    output logic                       o_waddr_ok,
    input  logic [ADDR_WD-1:0]         i_raddr,
    output logic [DATA_WD-1:0]         o_rdata,
    output logic                       o_raddr_ok,
    output logic [REG_NUM*DATA_WD-1:0] o_regs
);

    localparam int unsigned IDX_WD = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    // One extra bit so REG_NUM == 2**ADDR_WD is representable; compare never truncates.
    localparam logic [ADDR_WD:0] REG_LIMIT = (ADDR_WD + 1)'(REG_NUM);

    logic [DATA_WD-1:0] r_mem [REG_NUM];
    logic [IDX_WD-1:0]  w_widx;
    logic [IDX_WD-1:0]  w_ridx;

    assign o_waddr_ok = ({1'b0, i_waddr} < REG_LIMIT);
    assign o_raddr_ok = ({1'b0, i_raddr} < REG_LIMIT);
    assign w_widx     = i_waddr[IDX_WD-1:0];
    assign w_ridx     = i_raddr[IDX_WD-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && o_waddr_ok) begin
            r_mem[w_widx] <= i_wdata;
        end
    end

    assign o_rdata = o_raddr_ok ? r_mem[w_ridx] : '0;

    for (genvar g = 0; g < int'(REG_NUM); g++) begin : g_dump
        assign o_regs[g*DATA_WD +: DATA_WD] = r_mem[g];
    end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI-lite slave terminating AW/W/B and AR/R in a small register array.
// Write and read paths are independent, one outstanding transaction each.
// Ports:
//   i_clk, i_rst                     : clock, asynchronous active-high reset
//   i_awaddr/i_awvalid/o_awready     : write address channel
//   i_wdata/i_wvalid/o_wready        : write data channel
//   o_bresp/o_bvalid/i_bready        : write response channel (00 OKAY, 10 SLVERR)
//   i_araddr/i_arvalid/o_arready     : read address channel
//   o_rdata/o_rresp/o_rvalid/i_rready: read data channel (00 OKAY, 10 SLVERR)
//   o_regs                           : flat register contents
module axi_lite_slave_regfile
    import axi_lite_slave_regfile_pkg::*;
#(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned ADDR_WD = 8,
    parameter int unsigned REG_NUM = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [ADDR_WD-1:0]         i_awaddr,
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [DATA_WD-1:0]         i_wdata,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    output logic [1:0]                 o_bresp,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    input  logic [ADDR_WD-1:0]         i_araddr,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    output logic [DATA_WD-1:0]         o_rdata,
    output logic [1:0]                 o_rresp,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [REG_NUM*DATA_WD-1:0] o_regs
);

    wr_state_t          r_wr_state;
    wr_state_t          w_wr_next;
    rd_state_t          r_rd_state;
    rd_state_t          w_rd_next;

    logic [ADDR_WD-1:0] r_awaddr;
    logic [DATA_WD-1:0] r_wdata;
    logic [1:0]         r_bresp;
    logic [DATA_WD-1:0] r_rdata;
    logic [1:0]         r_rresp;

    logic               w_commit;
    logic [ADDR_WD-1:0] w_commit_addr;
    logic [DATA_WD-1:0] w_commit_data;
    logic               w_latch_aw;
    logic               w_latch_w;
    logic               w_waddr_ok;
    logic               w_arfire;
    logic [DATA_WD-1:0] w_rf_rdata;
    logic               w_raddr_ok;

    axi_lite_regfile #(
        .DATA_WD (DATA_WD),
        .ADDR_WD (ADDR_WD),
        .REG_NUM (REG_NUM)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (w_commit),
        .i_waddr    (w_commit_addr),
        .i_wdata    (w_commit_data),
        .o_waddr_ok (w_waddr_ok),
        .i_raddr    (i_araddr),
        .o_rdata    (w_rf_rdata),
        .o_raddr_ok (w_raddr_ok),
        .o_regs     (o_regs)
    );

    // ---------------- write path ----------------
    // Ready outputs decode from state only, so in a ready state valid alone means fire.
    always_comb begin
        w_wr_next     = r_wr_state;
        o_awready     = 1'b0;
        o_wready      = 1'b0;
        o_bvalid      = 1'b0;
        w_commit      = 1'b0;
        w_commit_addr = i_awaddr;
        w_commit_data = i_wdata;
        w_latch_aw    = 1'b0;
        w_latch_w     = 1'b0;
        unique case (r_wr_state)
            WR_IDLE: begin
                o_awready = 1'b1;
                o_wready  = 1'b1;
                if (i_awvalid && i_wvalid) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end else if (i_awvalid) begin
                    w_latch_aw = 1'b1;
                    w_wr_next  = WR_GOT_AW;
                end else if (i_wvalid) begin
                    w_latch_w = 1'b1;
                    w_wr_next = WR_GOT_W;
                end
            end
            WR_GOT_AW: begin
                o_wready      = 1'b1;
                w_commit_addr = r_awaddr;
                if (i_wvalid) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end
            end
            WR_GOT_W: begin
                o_awready     = 1'b1;
                w_commit_data = r_wdata;
                if (i_awvalid) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    w_wr_next = WR_IDLE;
                end
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_state <= WR_IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_latch_aw) begin
                r_awaddr <= i_awaddr;
            end
            if (w_latch_w) begin
                r_wdata <= i_wdata;
            end
            if (w_commit) begin
                r_bresp <= w_waddr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign o_bresp = r_bresp;

    // ---------------- read path ----------------
    assign o_arready = (r_rd_state == RD_IDLE);
    assign o_rvalid  = (r_rd_state == RD_DATA);
    assign w_arfire  = i_arvalid && o_arready;

    always_comb begin
        w_rd_next = r_rd_state;
        unique case (r_rd_state)
            RD_IDLE: if (w_arfire) w_rd_next = RD_DATA;
            RD_DATA: if (i_rready) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    // Capturing the pre-edge storage value gives old-data semantics on a same-edge commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_state <= RD_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_arfire) begin
                r_rdata <= w_rf_rdata;
                r_rresp <= w_raddr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_rresp = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
module tb_axi_lite_slave_regfile;

    localparam int NREG = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   awaddr, wdata, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [7:0]   rdata;
    logic [127:0] regs;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] model [NREG];

    always #5 clk = ~clk;

    axi_lite_slave_regfile #(
        .DATA_WD (8),
        .ADDR_WD (8),
        .REG_NUM (NREG)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .i_araddr  (araddr),
        .i_arvalid (arvalid),
        .o_arready (arready),
        .o_rdata   (rdata),
        .o_rresp   (rresp),
        .o_rvalid  (rvalid),
        .i_rready  (rready),
        .o_regs    (regs)
    );

    // ---------------- reference model ----------------
    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NREG; i++) f[i*8 +: 8] = model[i];
        return f;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [7:0] a);
        return (int'(a) < NREG) ? 2'b10 ^ 2'b10 : 2'b10;
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        return (int'(a) < NREG) ? model[a[3:0]] : 8'h00;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (int'(a) < NREG) model[a[3:0]] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- bus drivers (stimulus only) ----------------
    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int lead,
                            input int bwait, output logic [1:0] resp, output bit ok);
        int  aw_at, w_at, cyc;
        bit  aw_done, w_done, af, wf;
        aw_at = (lead > 0) ? lead : 0;
        w_at  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; ok = 1; cyc = 0; resp = 2'bxx;
        awaddr = a; wdata = d;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (cyc >= aw_at);
            wvalid  = !w_done && (cyc >= w_at);
            af = awvalid && awready;
            wf = wvalid && wready;
            tick();
            aw_done |= af;
            w_done  |= wf;
            cyc++;
            if (cyc > 50) begin ok = 0; break; end
        end
        awvalid = 0; wvalid = 0;
        repeat (bwait) tick();
        cyc = 0;
        while (!bvalid && ok) begin
            tick();
            if (++cyc > 50) ok = 0;
        end
        resp = bresp;
        bready = 1;
        tick();
        bready = 0;
    endtask

    task automatic do_read(input logic [7:0] a, input int rwait, output logic [7:0] d,
                           output logic [1:0] resp, output bit ok);
        int cyc;
        ok = 1; cyc = 0; d = 'x; resp = 'x;
        araddr = a; arvalid = 1;
        while (!arready) begin
            tick();
            if (++cyc > 50) begin ok = 0; break; end
        end
        tick();
        arvalid = 0;
        repeat (rwait) tick();
        cyc = 0;
        while (!rvalid && ok) begin
            tick();
            if (++cyc > 50) ok = 0;
        end
        d = rdata; resp = rresp;
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic apply_reset();
        rst = 1;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        tick();
        rst = 0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            n_err++;
            $display("FAIL reset_hs: got %b want 11100", {awready, wready, arready, bvalid, rvalid});
        end
        n_cmp++;
        if ({bresp, rresp, rdata} !== 12'h000 || regs !== 128'h0) begin
            n_err++;
            $display("FAIL reset_vals: bresp=%b rresp=%b rdata=%h regs=%h want all 0",
                     bresp, rresp, rdata, regs);
        end
    endtask

    task automatic test_simul_write();
        awaddr = 8'd3; wdata = 8'hA5; awvalid = 1; wvalid = 1; bready = 1;
        tick();
        awvalid = 0; wvalid = 0;
        model_write(8'd3, 8'hA5);
        n_cmp++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_err++;
            $display("FAIL simul_bvalid: bvalid=%b bresp=%b want 1 00", bvalid, bresp);
        end
        n_cmp++;
        if (regs[3*8 +: 8] !== 8'hA5) begin
            n_err++;
            $display("FAIL simul_reg3: got %h want a5", regs[3*8 +: 8]);
        end
        tick();
        bready = 0;
        n_cmp++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_err++;
            $display("FAIL simul_bdone: bvalid=%b awready=%b want 0 1", bvalid, awready);
        end
    endtask

    task automatic test_w_first();
        bit bad;
        wdata = 8'h3C; wvalid = 1;
        tick();
        wvalid = 0;
        bad = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin awaddr = 8'd5; awvalid = 1; end
            if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) bad = 1;
            if (c < 4) tick();
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL wfirst_wait: wready/bvalid/awready got %b%b%b want 001",
                     wready, bvalid, awready);
        end
        tick();
        awvalid = 0;
        model_write(8'd5, 8'h3C);
        n_cmp++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || regs !== model_flat()) begin
            n_err++;
            $display("FAIL wfirst_commit: bvalid=%b bresp=%b regs=%h want 1 00 %h",
                     bvalid, bresp, regs, model_flat());
        end
        bready = 1;
        tick();
        bready = 0;
    endtask

    task automatic test_out_of_range();
        logic [1:0] r;
        logic [7:0] d;
        bit ok;
        do_write(8'd20, 8'hFF, 0, 0, r, ok);
        n_cmp++;
        if (!ok || r !== 2'b10 || regs !== model_flat()) begin
            n_err++;
            $display("FAIL oor_write: ok=%0d bresp=%b regs=%h want 10 %h", ok, r, regs, model_flat());
        end
        do_read(8'd20, 0, d, r, ok);
        n_cmp++;
        if (!ok || d !== 8'h00 || r !== 2'b10) begin
            n_err++;
            $display("FAIL oor_read: ok=%0d rdata=%h rresp=%b want 00 10", ok, d, r);
        end
    endtask

    task automatic test_read_stall();
        bit bad;
        araddr = 8'd3; arvalid = 1; rready = 0;
        tick();
        arvalid = 0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (rvalid !== 1'b1 || rdata !== exp_read(8'd3) || rresp !== 2'b00 || arready !== 1'b0)
                bad = 1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL read_stall: rvalid=%b rdata=%h arready=%b want 1 %h 0",
                     rvalid, rdata, arready, exp_read(8'd3));
        end
        rready = 1;
        tick();
        rready = 0;
        n_cmp++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_err++;
            $display("FAIL read_done: rvalid=%b arready=%b want 0 1", rvalid, arready);
        end
    endtask

    task automatic test_back_to_back();
        bit bad, ok;
        logic [1:0] r;
        awaddr = 8'd9; wdata = 8'h5A; awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        model_write(8'd9, 8'h5A);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad = 1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL bstall: bvalid=%b awready=%b wready=%b want 1 0 0",
                     bvalid, awready, wready);
        end
        bready = 1;
        tick();
        bready = 0;
        do_write(8'd10, 8'hC3, 0, 0, r, ok);
        model_write(8'd10, 8'hC3);
        n_cmp++;
        if (!ok || r !== 2'b00 || regs !== model_flat()) begin
            n_err++;
            $display("FAIL b2b_write: ok=%0d bresp=%b regs=%h want 00 %h", ok, r, regs, model_flat());
        end
    endtask

    task automatic test_collision();
        logic [1:0] r;
        logic [7:0] d;
        bit ok;
        do_write(8'd7, 8'h00, 0, 0, r, ok);
        model_write(8'd7, 8'h00);
        awaddr = 8'd7; wdata = 8'h11; awvalid = 1; wvalid = 1;
        araddr = 8'd7; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 8'h00) begin
            n_err++;
            $display("FAIL collide_old: rvalid=%b rdata=%h want 1 00", rvalid, rdata);
        end
        model_write(8'd7, 8'h11);
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        do_read(8'd7, 0, d, r, ok);
        n_cmp++;
        if (!ok || d !== 8'h11 || r !== 2'b00) begin
            n_err++;
            $display("FAIL collide_new: rdata=%h rresp=%b want 11 00", d, r);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, d, rd;
        logic [1:0] r;
        bit ok;
        for (int it = 0; it < 30; it++) begin
            a = 8'($urandom_range(0, 23));
            d = 8'($urandom);
            do_write(a, d, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)), r, ok);
            model_write(a, d);
            n_cmp++;
            if (!ok || r !== exp_resp(a) || regs !== model_flat()) begin
                n_err++;
                $display("FAIL rand_write[%0d] a=%0d: bresp=%b regs=%h want %b %h",
                         it, a, r, regs, exp_resp(a), model_flat());
            end
            a = 8'($urandom_range(0, 23));
            do_read(a, int'($urandom_range(0, 3)), rd, r, ok);
            n_cmp++;
            if (!ok || rd !== exp_read(a) || r !== exp_resp(a)) begin
                n_err++;
                $display("FAIL rand_read[%0d] a=%0d: rdata=%h rresp=%b want %h %b",
                         it, a, rd, r, exp_read(a), exp_resp(a));
            end
        end
    endtask

    task automatic test_reset_mid();
        awaddr = 8'd2; wdata = 8'h77; awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        n_cmp++;
        if (bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: bvalid=%b want 1", bvalid);
        end
        rst = 1;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        n_cmp++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || regs !== 128'h0) begin
            n_err++;
            $display("FAIL mid_reset: bvalid=%b awready=%b wready=%b regs=%h want 0 1 1 0",
                     bvalid, awready, wready, regs);
        end
        tick();
        rst = 0;
        tick();
    endtask

    initial begin
        rst = 1; awaddr = 0; wdata = 0; araddr = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        apply_reset();
        test_reset();
        test_simul_write();
        test_w_first();
        test_out_of_range();
        test_read_stall();
        test_back_to_back();
        test_collision();
        test_random();
        test_reset_mid();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
